alu_seq: RTL and testbench

Parametrised multi-cycle ALU that replaces the purely combinational ALU in the datapath. It keeps the same 4-bit opcode map. Add, subtract, logic, negate, not, shift and rotate complete in one cycle. Signed multiply uses iterative radix-2 Booth; signed divide uses non-restoring division. Handshake is start/busy/done, so the control unit can stall for multiply/divide instead of relying on an unbounded combinational path into the Z register.

---
 rtl/alu_seq.sv | 218 +++++++++++++++++++++
 tb/tb_alu_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with Booth multiply and, when ALU_SEQ_DIV_EN is defined, non-restoring divide.
// Latency: 1 edge for single-cycle/error ops, WIDTH+1 for mul, WIDTH+2 for div.
// Backpressure: start is accepted only in IDLE or DONE; a start seen while busy is dropped.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               err
);
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NEG  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHRA = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_ROL  = 4'b1011;
  localparam logic [3:0] OP_ROR  = 4'b1100;
  localparam int         CW      = SHW + 1;

  typedef enum logic [2:0] {S_IDLE, S_ONE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  state_t state, state_nxt;

  logic               accept, go_mul, go_div;
  logic [WIDTH-1:0]   areg, breg, qreg;
  logic [3:0]         opr;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     acc, msx, bsum;
  logic               qm1;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] rol_w, ror_w, one_res;
  logic [WIDTH-1:0]   lo, hi;
  logic               one_err;

  assign go_mul = (op == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
  assign go_div = (op == OP_DIV) && (b != '0);
`else
  assign go_div = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done      = (state == S_DONE);
        state_nxt = S_IDLE;
        if (start) begin
          accept    = 1'b1;
          state_nxt = go_mul ? S_MUL : (go_div ? S_DIV : S_ONE);
        end
      end
      S_ONE: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_MUL: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = S_DONE;
      end
`ifdef ALU_SEQ_DIV_EN
      S_DIV: begin
        busy = 1'b1;
        if (cnt == '0) state_nxt = S_FIX;
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Booth step: acc is one bit wider than the operand so adding/subtracting the most negative multiplicand cannot overflow.
  assign msx = {areg[WIDTH-1], areg};
  always_comb begin
    case ({qreg[0], qm1})
      2'b10:   bsum = acc - msx;
      2'b01:   bsum = acc + msx;
      default: bsum = acc;
    endcase
  end

  assign sh    = breg[SHW-1:0];
  assign rol_w = {areg, areg} << sh;
  assign ror_w = {areg, areg} >> sh;

  always_comb begin
    lo      = '0;
    hi      = '0;
    one_err = 1'b0;
    case (opr)
      OP_ADD:  lo = areg + breg;
      OP_SUB:  lo = areg - breg;
      OP_AND:  lo = areg & breg;
      OP_OR:   lo = areg | breg;
      OP_NEG:  lo = -areg;
      OP_NOT:  lo = ~areg;
      OP_SHRA: lo = $signed(areg) >>> sh;
      OP_SHL:  lo = areg << sh;
      OP_SHR:  lo = areg >> sh;
      OP_ROL:  lo = rol_w[2*WIDTH-1:WIDTH];
      OP_ROR:  lo = ror_w[WIDTH-1:0];
      OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
        hi = areg;
        lo = '1;
`endif
        one_err = 1'b1;
      end
      default: one_err = 1'b1;
    endcase
    one_res = {hi, lo};
  end

`ifdef ALU_SEQ_DIV_EN
  // Divider runs on magnitudes; signs are applied once in FIX.
  logic [WIDTH+1:0] rem, rem_sh, rem_nxt, dext;
  logic [WIDTH-1:0] amag, dmag, rem_fix, quo, rmd;
  assign amag    = a[WIDTH-1] ? -a : a;
  assign dmag    = breg[WIDTH-1] ? -breg : breg;
  assign dext    = {2'b00, dmag};
  assign rem_sh  = {rem[WIDTH:0], qreg[WIDTH-1]};
  assign rem_nxt = rem[WIDTH+1] ? rem_sh + dext : rem_sh - dext;
  assign rem_fix = rem[WIDTH+1] ? rem[WIDTH-1:0] + dmag : rem[WIDTH-1:0];
  assign quo     = (areg[WIDTH-1] ^ breg[WIDTH-1]) ? -qreg : qreg;
  assign rmd     = areg[WIDTH-1] ? -rem_fix : rem_fix;
`endif

  // Iterating states count cnt down from WIDTH; the cnt==0 cycle finishes without stepping.
  always_ff @(posedge clock) begin
    if (clear) begin
      areg   <= '0;
      breg   <= '0;
      opr    <= '0;
      cnt    <= '0;
      acc    <= '0;
      qreg   <= '0;
      qm1    <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      err    <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      rem    <= '0;
`endif
    end else if (accept) begin
      areg <= a;
      breg <= b;
      opr  <= op;
      cnt  <= CW'(WIDTH);
      acc  <= '0;
      qm1  <= 1'b0;
      qreg <= b;
`ifdef ALU_SEQ_DIV_EN
      rem  <= '0;
      if (op == OP_DIV) qreg <= amag;
`endif
    end else begin
      case (state)
        S_ONE: begin
          result <= one_res;
          zero   <= (one_res == '0);
          err    <= one_err;
        end
        S_MUL: begin
          if (cnt != '0) begin
            acc  <= {bsum[WIDTH], bsum[WIDTH:1]};
            qreg <= {bsum[0], qreg[WIDTH-1:1]};
            qm1  <= qreg[0];
            cnt  <= cnt - 1'b1;
          end else begin
            result <= {acc[WIDTH-1:0], qreg};
            zero   <= ({acc[WIDTH-1:0], qreg} == '0);
            err    <= 1'b0;
          end
        end
`ifdef ALU_SEQ_DIV_EN
        S_DIV: begin
          if (cnt != '0) begin
            rem  <= rem_nxt;
            qreg <= {qreg[WIDTH-2:0], ~rem_nxt[WIDTH+1]};
            cnt  <= cnt - 1'b1;
          end
        end
        S_FIX: begin
          result <= {rmd, quo};
          zero   <= ({rmd, quo} == '0);
          err    <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=32): directed vector table plus hand sequences for
// start-while-busy, start in the DONE cycle and clear during an iteration.
module tb_alu_seq;
  logic        clock, clear, start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done, zero, err;
  logic [63:0] result;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [63:0] res;
    logic        z;
    logic        e;
  } vec_t;
  vec_t vecs[$];

  alu_seq #(.WIDTH(32)) dut (
    .clock (clock),
    .clear (clear),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result),
    .zero  (zero),
    .err   (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic addv(input string nm, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                      input int lat, input logic [63:0] r, input logic z, input logic e);
    vec_t v;
    v.nm = nm; v.op = o; v.a = x; v.b = y; v.lat = lat; v.res = r; v.z = z; v.e = e;
    vecs.push_back(v);
  endtask

  // Starts an op from IDLE, counts edges after the sampling edge until done, checks outputs and the pulse width.
  task automatic run_op(input vec_t v);
    int n;
    n = 0;
    @(negedge clock);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    @(posedge clock); #1;
    start = 1'b0;
    while (!done && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk({v.nm, ".lat"}, 64'(n), 64'(v.lat));
    chk({v.nm, ".res"}, result, v.res);
    chk({v.nm, ".zero"}, 64'(zero), 64'(v.z));
    chk({v.nm, ".err"}, 64'(err), 64'(v.e));
    @(posedge clock); #1;
    chk({v.nm, ".pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int   n;
    logic seen;
    vec_t v;
    logic [3:0] long_op;

    clear = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.result", result, 64'd0);
    chk("rst.zero", 64'(zero), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    @(negedge clock);
    clear = 1'b0;

    addv("add",    4'h0, 32'h0000_0002, 32'h0000_0003, 1, 64'h0000_0000_0000_0005, 1'b0, 1'b0);
    addv("sub0",   4'h1, 32'h0000_0005, 32'h0000_0005, 1, 64'h0,                   1'b1, 1'b0);
    addv("and",    4'h2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 64'h0000_0000_00F0_00F0, 1'b0, 1'b0);
    addv("or",     4'h3, 32'h0000_000F, 32'h0000_00F0, 1, 64'h0000_0000_0000_00FF, 1'b0, 1'b0);
    addv("neg",    4'h4, 32'h0000_0005, 32'h0,         1, 64'h0000_0000_FFFF_FFFB, 1'b0, 1'b0);
    addv("not",    4'h5, 32'h0000_0005, 32'h0,         1, 64'h0000_0000_FFFF_FFFA, 1'b0, 1'b0);
    addv("shra",   4'h6, 32'h8000_0000, 32'h0000_0004, 1, 64'h0000_0000_F800_0000, 1'b0, 1'b0);
    addv("shl",    4'h8, 32'h0000_0005, 32'h0000_0003, 1, 64'h0000_0000_0000_0028, 1'b0, 1'b0);
    addv("shlmsk", 4'h8, 32'h0000_0001, 32'h0000_0021, 1, 64'h0000_0000_0000_0002, 1'b0, 1'b0);
    addv("shr31",  4'h9, 32'h8000_0000, 32'h0000_001F, 1, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
    addv("rol",    4'hB, 32'h8000_0001, 32'h0000_0001, 1, 64'h0000_0000_0000_0003, 1'b0, 1'b0);
    addv("ror",    4'hC, 32'h0000_0005, 32'h0000_0001, 1, 64'h0000_0000_8000_0002, 1'b0, 1'b0);
    addv("ror0",   4'hC, 32'h0000_0005, 32'h0000_0000, 1, 64'h0000_0000_0000_0005, 1'b0, 1'b0);
    addv("bad13",  4'hD, 32'h1234_5678, 32'h1,         1, 64'h0,                   1'b1, 1'b1);
    addv("bad15",  4'hF, 32'h1234_5678, 32'h1,         1, 64'h0,                   1'b1, 1'b1);
    addv("mulneg", 4'h7, 32'hFFFF_FFFB, 32'h0000_0003, 33, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 1'b0);
    addv("mulmax", 4'h7, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 33, 64'h3FFF_FFFF_0000_0001, 1'b0, 1'b0);
    addv("mulmin", 4'h7, 32'h8000_0000, 32'h8000_0000, 33, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
    addv("mul0",   4'h7, 32'h0000_0000, 32'h0001_2345, 33, 64'h0,                  1'b1, 1'b0);
`ifdef ALU_SEQ_DIV_EN
    addv("divneg", 4'hA, 32'hFFFF_FFF9, 32'h0000_0002, 34, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    addv("divpos", 4'hA, 32'h0000_0064, 32'h0000_0007, 34, 64'h0000_0002_0000_000E, 1'b0, 1'b0);
    addv("divnb",  4'hA, 32'h0000_0007, 32'hFFFF_FFFE, 34, 64'h0000_0001_FFFF_FFFD, 1'b0, 1'b0);
    addv("divz",   4'hA, 32'h0000_000A, 32'h0000_0000, 1,  64'h0000_000A_FFFF_FFFF, 1'b0, 1'b1);
    long_op = 4'hA;
`else
    addv("divneg", 4'hA, 32'hFFFF_FFF9, 32'h0000_0002, 1, 64'h0, 1'b1, 1'b1);
    addv("divpos", 4'hA, 32'h0000_0064, 32'h0000_0007, 1, 64'h0, 1'b1, 1'b1);
    addv("divz",   4'hA, 32'h0000_000A, 32'h0000_0000, 1, 64'h0, 1'b1, 1'b1);
    long_op = 4'h7;
`endif

    foreach (vecs[i]) run_op(vecs[i]);

    // Start pulsed while a mul is iterating must be dropped; then start in the DONE cycle.
    @(negedge clock);
    start = 1'b1; op = 4'h7; a = 32'hFFFF_FFFB; b = 32'h0000_0003;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clock); #1;
      n++;
      if (n == 5) begin
        start = 1'b1; op = 4'h0; a = 32'h1; b = 32'h1;
      end else if (n == 6) begin
        start = 1'b0; a = '1; b = '1;
      end
    end
    chk("ign.lat", 64'(n), 64'd33);
    chk("ign.res", result, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("ign.busy", 64'(busy), 64'd0);
    start = 1'b1; op = 4'h0; a = 32'h2; b = 32'h3;
    @(posedge clock); #1;
    start = 1'b0;
    chk("b2b.done0", 64'(done), 64'd0);
    chk("b2b.busy", 64'(busy), 64'd1);
    @(posedge clock); #1;
    chk("b2b.done1", 64'(done), 64'd1);
    chk("b2b.res", result, 64'h0000_0000_0000_0005);
    @(posedge clock); #1;
    chk("b2b.pulse", 64'(done), 64'd0);

    // Clear in the middle of a long operation discards it.
    @(negedge clock);
    start = 1'b1; op = long_op; a = 32'hFFFF_FFF9; b = 32'h0000_0002;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("clr.busy_pre", 64'(busy), 64'd1);
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    chk("clr.busy", 64'(busy), 64'd0);
    chk("clr.done", 64'(done), 64'd0);
    chk("clr.result", result, 64'd0);
    chk("clr.err", 64'(err), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) seen = 1'b1;
    end
    chk("clr.nodone", 64'(seen), 64'd0);
    v.nm = "postclr"; v.op = 4'h0; v.a = 32'h1; v.b = 32'h1; v.lat = 1;
    v.res = 64'h0000_0000_0000_0002; v.z = 1'b0; v.e = 1'b0;
    run_op(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
